// File: rtl/itr_ctrl_if.sv
// Core I/O bus as seen by the interrupt controller: output-port writes and input-port reads.
interface itr_ctrl_if #(
    parameter int NUBITS = 32,
    parameter int NBIOA  = 3
);
    logic              out_en;
    logic [NBIOA-1:0]  addr_out;
    logic [NUBITS-1:0] data_out;
    logic              req_in;
    logic [NBIOA-1:0]  addr_in;
    logic [NUBITS-1:0] io_rd_data;
    logic              io_rd_valid;

    modport master (
        output out_en, addr_out, data_out, req_in, addr_in,
        input  io_rd_data, io_rd_valid
    );

    modport slave (
        input  out_en, addr_out, data_out, req_in, addr_in,
        output io_rd_data, io_rd_valid
    );
endinterface

// File: rtl/itr_ctrl.sv
// Interrupt controller: syncs and edge-detects NSRC request lines, masks them, fires a one-cycle itr
// for the lowest pending source and holds off further interrupts until EOI plus GAPCY idle cycles.
module itr_ctrl #(
    parameter int NUBITS    = 32,
    parameter int NSRC      = 8,
    parameter int NBIOA     = 3,
    parameter int MASK_ADR  = 6,
    parameter int EOI_ADR   = 7,
    parameter int CAUSE_ADR = 6,
    parameter int PEND_ADR  = 7,
    parameter int GAPCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src_i,
    itr_ctrl_if.slave       bus,
    output logic            itr_o,
    output logic            busy_o
);
    localparam int CW = (NSRC > 1) ? $clog2(NSRC) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] SERV = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [NSRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [CW-1:0]   cause_q, cause_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      state_q, state_d;
    logic            itr_q, busy_q;

    logic [NSRC-1:0] rise, clr, armed;
    logic [CW-1:0]   sel_idx;
    logic            mask_wr, eoi_wr;

    assign mask_wr = bus.out_en && (bus.addr_out == NBIOA'(MASK_ADR));
    assign eoi_wr  = bus.out_en && (bus.addr_out == NBIOA'(EOI_ADR));
    assign rise    = sync2_q & ~prev_q;
    assign armed   = pend_q & mask_q;

    // Descending scan so the lowest armed index is the one left standing.
    always_comb begin
        sel_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (armed[i]) sel_idx = CW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (|armed) begin
                    state_d = FIRE;
                    cause_d = sel_idx;
                    clr     = NSRC'(1) << sel_idx;
                end
            end
            FIRE: state_d = SERV;
            SERV: begin
                if (eoi_wr) begin
                    state_d = GAP;
                    cnt_d   = 4'(GAPCY - 1);
                end
            end
            default: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
        endcase
        // A fresh rising edge beats the clear of the source being dispatched.
        pend_d = (pend_q & ~clr) | rise;
        mask_d = mask_wr ? bus.data_out[NSRC-1:0] : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            itr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            itr_q   <= (state_d == FIRE);
            busy_q  <= (state_d == FIRE) || (state_d == SERV);
        end
    end

    assign itr_o  = itr_q;
    assign busy_o = busy_q;

    logic [NUBITS-1:0] cause_word, pend_word;
    logic              hit_cause, hit_pend;

    assign hit_cause = bus.req_in && (bus.addr_in == NBIOA'(CAUSE_ADR));
    assign hit_pend  = bus.req_in && (bus.addr_in == NBIOA'(PEND_ADR));

    always_comb begin
        cause_word             = '0;
        cause_word[NUBITS-1]   = busy_q;
        cause_word[CW-1:0]     = cause_q;
        pend_word              = '0;
        pend_word[NSRC-1:0]    = pend_q;
        bus.io_rd_valid        = hit_cause || hit_pend;
        bus.io_rd_data         = '0;
        if (hit_cause)     bus.io_rd_data = cause_word;
        else if (hit_pend) bus.io_rd_data = pend_word;
    end

    logic unused_data;
    assign unused_data = ^bus.data_out[NUBITS-1:NSRC];
endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;
    localparam int W_NONE = 0, W_MASK = 1, W_EOI = 2;
    localparam int R_NONE = 0, R_CAUSE = 1, R_PEND = 2, R_OTH = 3;

    typedef struct {
        logic [7:0]  irq;
        logic        oe;
        logic [2:0]  ao;
        logic [31:0] dout;
        logic        rq;
        logic [2:0]  ai;
        logic        e_itr;
        logic        e_busy;
        logic        e_vld;
        logic [31:0] e_dat;
    } vec_t;

    typedef struct {
        logic        itr;
        logic        busy;
        logic        vld;
        logic [31:0] dat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = '0;
    logic       itr, busy;

    itr_ctrl_if #(.NUBITS(32), .NBIOA(3)) bus ();

    itr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src_i (irq_src),
        .bus       (bus),
        .itr_o     (itr),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t v(input logic [7:0] irq, input int wr, input logic [31:0] wd,
                               input int rd, input logic [31:0] rdat,
                               input logic e_itr, input logic e_busy);
        vec_t r;
        r.irq    = irq;
        r.oe     = (wr != W_NONE);
        r.ao     = (wr == W_EOI) ? 3'd7 : 3'd6;
        r.dout   = wd;
        r.rq     = (rd != R_NONE);
        r.ai     = (rd == R_CAUSE) ? 3'd6 : (rd == R_PEND) ? 3'd7 : (rd == R_OTH) ? 3'd3 : 3'd0;
        r.e_itr  = e_itr;
        r.e_busy = e_busy;
        r.e_vld  = (rd == R_CAUSE) || (rd == R_PEND);
        r.e_dat  = r.e_vld ? rdat : 32'h0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t r);
        irq_src      = r.irq;
        bus.out_en   = r.oe;
        bus.addr_out = r.ao;
        bus.data_out = r.dout;
        bus.req_in   = r.rq;
        bus.addr_in  = r.ai;
    endtask

    // One table row per cycle: drive at negedge, push expectation, compare 1ns later, then cross the edge.
    task automatic run_row(input vec_t r, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(r);
        e.itr = r.e_itr; e.busy = r.e_busy; e.vld = r.e_vld; e.dat = r.e_dat;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        check($sformatf("row%0d itr", idx),  {31'b0, itr},             {31'b0, got.itr});
        check($sformatf("row%0d busy", idx), {31'b0, busy},            {31'b0, got.busy});
        check($sformatf("row%0d vld", idx),  {31'b0, bus.io_rd_valid}, {31'b0, got.vld});
        check($sformatf("row%0d dat", idx),  bus.io_rd_data,           got.dat);
    endtask

    task automatic idle_inputs();
        drive(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.req_in  = 1'b1;
        bus.addr_in = a;
        #1;
        check(name, bus.io_rd_data, exp);
        bus.req_in  = 1'b0;
        bus.addr_in = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst itr", {31'b0, itr}, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        read_check("rst pend", 3'd7, 32'h0);
        read_check("rst cause", 3'd6, 32'h0);

        // Single pulse on src 0
        tbl.push_back(v(8'h00, W_MASK, 32'h01, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h01, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h01, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_CAUSE, 32'h80000000, 1, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 0, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_CAUSE, 32'h0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_OTH, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        // Two sources at once: 3 then 5
        tbl.push_back(v(8'h28, W_MASK, 32'hFF, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h28, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_CAUSE, 32'h80000003, 1, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h20, 0, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_CAUSE, 32'h80000005, 1, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 0, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 0, 0));
        // Masked source pends, fires once unmasked; decision on the write cycle uses the old mask
        tbl.push_back(v(8'h04, W_MASK, 32'h00, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h04, 0, 0));
        tbl.push_back(v(8'h00, W_MASK, 32'h04, R_PEND, 32'h04, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 1, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_CAUSE, 32'h80000002, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 0, 0));
        // New edge while in service waits for EOI, then fires GAPCY+1 cycles after it
        tbl.push_back(v(8'h01, W_MASK, 32'h01, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h01, W_NONE, 0, R_NONE, 0, 1, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h01, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_CAUSE, 32'h80000000, 1, 1));
        tbl.push_back(v(8'h00, W_EOI, 0, R_NONE, 0, 0, 1));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_NONE, 0, 0, 0));
        tbl.push_back(v(8'h00, W_NONE, 0, R_PEND, 32'h00, 0, 0));

        foreach (tbl[i]) run_row(tbl[i], i);

        // Reset while in service
        @(negedge clk);
        irq_src = 8'h01;
        repeat (4) @(negedge clk);
        irq_src = 8'h00;
        #1;
        check("pre-rst busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-rst busy", {31'b0, busy}, 32'h0);
        check("mid-rst itr", {31'b0, itr}, 32'h0);
        read_check("mid-rst pend", 3'd7, 32'h0);
        read_check("mid-rst cause", 3'd6, 32'h0);

        // EOI in IDLE is ignored; a held level fires exactly once
        bus.out_en = 1'b1; bus.addr_out = 3'd7; bus.data_out = 32'h0;
        @(negedge clk);
        bus.out_en = 1'b0;
        repeat (3) begin
            #1;
            check("idle-eoi busy", {31'b0, busy}, 32'h0);
            check("idle-eoi itr", {31'b0, itr}, 32'h0);
            @(negedge clk);
        end
        bus.out_en = 1'b1; bus.addr_out = 3'd6; bus.data_out = 32'h01;
        @(negedge clk);
        bus.out_en = 1'b0;
        npulse = 0;
        irq_src = 8'h01;
        for (int i = 0; i < 110; i++) begin
            bus.out_en   = (i == 15);
            bus.addr_out = 3'd7;
            if (i == 100) irq_src = 8'h00;
            #1;
            if (itr) npulse++;
            @(negedge clk);
        end
        bus.out_en = 1'b0;
        #1;
        check("level pulses", npulse, 32'd1);
        check("level busy end", {31'b0, busy}, 32'h0);
        read_check("level pend end", 3'd7, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
